sha3_arbiter: RTL and testbench

- Round-robin front end that shares one sha3 hashing engine (single-block SHA3, N-bit message, MDLEN-bit digest) among NREQ requesters.
- Accepts a message from one requester and holds it stable on the engine input for the whole hash.
- Sequences the engine's request/result handshakes, captures the digest and returns it to the requester that owns it.
- Sits between client ports (bus slaves, DMA channels) and the single engine instance.

---
 rtl/sha3_pkg.sv | 20 ++
 rtl/sha3_arbiter_rr_pick.sv | 32 +++
 rtl/sha3_arbiter.sv | 156 +++++++++++++++
 tb/tb_sha3_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared definitions for the sha3 engine and its front ends: default widths
// and the arbiter state encoding.
package sha3_pkg;

  localparam int SHA3_N     = 128;
  localparam int SHA3_MDLEN = 256;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RES = 2'd2;
  localparam logic [1:0] ST_DELIVER  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    ISSUE    = ST_ISSUE,
    WAIT_RES = ST_WAIT_RES,
    DELIVER  = ST_DELIVER
  } state_t;

endpackage

// File: rtl/sha3_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit strictly after
// rr_ptr, wrapping modulo NREQ, so the requester at rr_ptr has lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [IDW:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (req[cand[IDW-1:0]]) begin
        any = 1'b1;
        idx = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/sha3_arbiter.sv
// Round-robin front end sharing one single-block sha3 engine among NREQ
// requesters; holds the accepted message on the engine input for the whole job.
module sha3_arbiter
  import sha3_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int N     = SHA3_N,
  parameter int MDLEN = SHA3_MDLEN,
  parameter int LATW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] md_in,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   res_valid,
  input  logic [NREQ-1:0]   res_ready,
  output logic [MDLEN-1:0]  md_out,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic [LATW-1:0]   last_lat,
  output logic [N-1:0]      eng_md_in,
  output logic              eng_req_valid,
  input  logic              eng_req_ready,
  input  logic              eng_req_busy,
  input  logic              eng_res_valid,
  output logic              eng_res_ready,
  input  logic [MDLEN-1:0]  eng_md_out,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both 1. Client req_ready and engine res_ready are single-cycle pulses issued
  // the cycle after the accepting/capturing edge; res_valid and eng_req_valid
  // stay high until the partner's ready is sampled.

  state_t            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    grant_q;
  logic [N-1:0]      msg_q;
  logic [MDLEN-1:0]  md_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [NREQ-1:0]   res_valid_q;
  logic [LATW-1:0]   lat_q;
  logic [LATW-1:0]   lat_d;
  logic [LATW-1:0]   last_lat_q;
  logic              eng_req_valid_q;
  logic              eng_res_ready_q;
  logic              busy_q;

  logic              pick_any;
  logic [IDW-1:0]    pick_idx;
  logic [N-1:0]      pick_msg;
  logic              unused_eng_busy;

  assign unused_eng_busy = eng_req_busy;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    pick_msg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        pick_msg = md_in[i*N +: N];
      end
    end
  end

  assign lat_d = (lat_q == '1) ? lat_q : lat_q + LATW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= IDW'(NREQ-1);
      grant_q         <= '0;
      msg_q           <= '0;
      md_q            <= '0;
      req_ready_q     <= '0;
      res_valid_q     <= '0;
      lat_q           <= '0;
      last_lat_q      <= '0;
      eng_req_valid_q <= 1'b0;
      eng_res_ready_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      req_ready_q     <= '0;
      eng_res_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            req_ready_q     <= NREQ'(1) << pick_idx;
            msg_q           <= pick_msg;
            grant_q         <= pick_idx;
            lat_q           <= '0;
            eng_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          lat_q <= lat_d;
          if (eng_req_ready) begin
            eng_req_valid_q <= 1'b0;
            state_q         <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          lat_q <= lat_d;
          if (eng_res_valid) begin
            md_q            <= eng_md_out;
            eng_res_ready_q <= 1'b1;
            last_lat_q      <= lat_q;
            res_valid_q     <= NREQ'(1) << grant_q;
            state_q         <= DELIVER;
          end
        end
        DELIVER: begin
          // Only the owner's res_ready matters; the owner drops to lowest priority.
          if (res_ready[grant_q]) begin
            res_valid_q <= '0;
            rr_ptr_q    <= grant_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign res_valid     = res_valid_q;
  assign md_out        = md_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign last_lat      = last_lat_q;
  assign eng_md_in     = msg_q;
  assign eng_req_valid = eng_req_valid_q;
  assign eng_res_ready = eng_res_ready_q;
  assign dbg_state     = state_q;

  a_res_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(res_valid_q));
  a_busy_state: assert property (@(posedge clk) disable iff (!rst) busy_q == (state_q != IDLE));
  a_eng_valid:  assert property (@(posedge clk) disable iff (!rst) eng_req_valid_q == (state_q == ISSUE));
  a_deliver:    assert property (@(posedge clk) disable iff (!rst) (res_valid_q != '0) == (state_q == DELIVER));

endmodule

// File: tb/tb_sha3_arbiter.sv
// Directed bench for sha3_arbiter: behavioural engine model, stimulus process
// pushing expected digests, and a monitor popping them at each result handshake.
module tb_sha3_arbiter;
  import sha3_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int N     = 128;
  localparam int MDLEN = 256;
  localparam int LATW  = 16;

  localparam logic [N-1:0]     ABC_MSG = {24'h616263, 104'h0};
  localparam logic [MDLEN-1:0] ABC_MD  =
    256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
  localparam logic [N-1:0] MSG_A = 128'h11112222333344445555666677778888;
  localparam logic [N-1:0] MSG_B = 128'h99990000aaaabbbbccccddddeeeeffff;
  localparam logic [N-1:0] MSG_C = 128'hc0c0c0c0c0c0c0c0c0c0c0c0c0c0c0c0;
  localparam logic [N-1:0] MSG_D = 128'hd00dd00dd00dd00dd00dd00dd00dd00d;
  localparam logic [N-1:0] MSG_E = 128'h0000000000000000000000000000e0e0;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] md_in;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   res_valid;
  logic [NREQ-1:0]   res_ready;
  logic [MDLEN-1:0]  md_out;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic [LATW-1:0]   last_lat;
  logic [N-1:0]      eng_md_in;
  logic              eng_req_valid;
  logic              eng_req_ready;
  logic              eng_req_busy;
  logic              eng_res_valid;
  logic              eng_res_ready;
  logic [MDLEN-1:0]  eng_md_out;
  state_t            dbg_state;

  sha3_arbiter #(
    .NREQ (NREQ), .IDW (IDW), .N (N), .MDLEN (MDLEN), .LATW (LATW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .md_in         (md_in),
    .req_ready     (req_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .md_out        (md_out),
    .grant_id      (grant_id),
    .busy          (busy),
    .last_lat      (last_lat),
    .eng_md_in     (eng_md_in),
    .eng_req_valid (eng_req_valid),
    .eng_req_ready (eng_req_ready),
    .eng_req_busy  (eng_req_busy),
    .eng_res_valid (eng_res_valid),
    .eng_res_ready (eng_res_ready),
    .eng_md_out    (eng_md_out),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int unsigned cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  int checks;
  int failures;
  int eng_rdy_dly;
  int eng_lat;

  logic [IDW-1:0]   exp_id_q[$];
  logic [MDLEN-1:0] exp_md_q[$];
  logic [LATW-1:0]  exp_lat_q[$];

  function automatic logic [MDLEN-1:0] h(input logic [N-1:0] m);
    if (m == ABC_MSG) return ABC_MD;
    return {m ^ 128'h0123456789abcdeffedcba9876543210, ~{m[63:0], m[127:64]}};
  endfunction

  task automatic chk(input string name, input logic [MDLEN-1:0] act, input logic [MDLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int i, input logic [N-1:0] m);
    md_in[i*N +: N] = m;
  endtask

  task automatic push_exp(input int id, input logic [N-1:0] m);
    exp_id_q.push_back(IDW'(id));
    exp_md_q.push_back(h(m));
  endtask

  task automatic flush();
    exp_id_q.delete();
    exp_md_q.delete();
    exp_lat_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_md_out"}, md_out, '0);
    chk({tag, "_eng_md_in"}, eng_md_in, '0);
    chk({tag, "_ctrl"}, {req_ready, res_valid, grant_id, busy, last_lat,
                         eng_req_valid, eng_res_ready, dbg_state}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    repeat (3) tick();
    flush();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_accept(input logic [NREQ-1:0] exp, input string name);
    int n = 0;
    while (req_ready == '0 && n < 100) begin tick(); n++; end
    chk(name, req_ready, exp);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_id_q.size() != 0 && n < limit) begin tick(); n++; end
    if (exp_id_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_id_q.size());
    end
  endtask

  // ---------------- engine model ----------------
  int          e_st;
  int          e_cnt;
  int unsigned e_c0;
  logic [N-1:0] e_msg;
  initial begin
    eng_req_ready = 1'b0;
    eng_req_busy  = 1'b0;
    eng_res_valid = 1'b0;
    eng_md_out    = '0;
    e_st = 0;
    e_cnt = 0;
    e_c0 = 0;
    e_msg = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        eng_req_ready = 1'b0;
        eng_req_busy  = 1'b0;
        eng_res_valid = 1'b0;
        eng_md_out    = '0;
        e_st = 0;
      end else begin
        case (e_st)
          0: if (eng_req_valid) begin
            e_c0  = cyc;
            e_cnt = eng_rdy_dly;
            e_st  = 1;
            if (e_cnt == 0) begin eng_req_ready = 1'b1; e_st = 2; end
          end
          1: begin
            e_cnt--;
            if (e_cnt == 0) begin eng_req_ready = 1'b1; e_st = 2; end
          end
          2: begin
            eng_req_ready = 1'b0;
            eng_req_busy  = 1'b1;
            e_msg = eng_md_in;
            e_cnt = eng_lat;
            e_st  = 3;
          end
          3: begin
            if (e_cnt == 0) begin
              chk("eng_md_stable", eng_md_in, e_msg);
              eng_md_out    = h(eng_md_in);
              eng_res_valid = 1'b1;
              exp_lat_q.push_back((cyc - e_c0 > 32'hFFFF) ? 16'hFFFF : LATW'(cyc - e_c0));
              e_st = 4;
            end else begin
              e_cnt--;
            end
          end
          default: if (eng_res_ready) begin
            eng_res_valid = 1'b0;
            eng_req_busy  = 1'b0;
            e_st = 0;
          end
        endcase
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [IDW-1:0]   id;
    logic [MDLEN-1:0] md;
    forever begin
      @(negedge clk);
      if (rst && ((res_valid & res_ready) != '0)) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: res_valid=%b, required no result", res_valid);
        end else begin
          id = exp_id_q.pop_front();
          md = exp_md_q.pop_front();
          chk("res_valid_owner", res_valid, NREQ'(1) << id);
          chk("grant_id", grant_id, id);
          chk("md_out", md_out, md);
          if (exp_lat_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL last_lat_missing: got %0d, no engine job recorded", last_lat);
          end else begin
            chk("last_lat", last_lat, exp_lat_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    checks = 0;
    failures = 0;
    rst = 1'b0;
    req_valid = '0;
    res_ready = '0;
    md_in = '0;
    eng_rdy_dly = 1;
    eng_lat = 2;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check_reset_outputs("idle_after_reset");

    // Single request: "abc"
    set_msg(0, ABC_MSG);
    req_valid = 4'b0001;
    res_ready = 4'b1111;
    push_exp(0, ABC_MSG);
    tick();
    chk("req_ready_pulse", req_ready, 4'b0001);
    req_valid = '0;
    tick();
    chk("req_ready_one_cycle", req_ready, 4'b0000);
    n = 0;
    while (res_valid == '0 && n < 100) begin
      chk("eng_md_in_msg0", eng_md_in, ABC_MSG);
      tick();
      n++;
    end
    chk("res_valid0_rise", res_valid, 4'b0001);
    chk("md_out_abc", md_out, ABC_MD);
    chk("last_lat_job1", last_lat, 16'd5);
    chk("busy_during_deliver", busy, 1'b1);
    tick();
    chk("busy_drop", busy, 1'b0);
    chk("res_valid_drop", res_valid, 4'b0000);
    drain(50);

    // Round robin with all requesters active
    do_reset();
    eng_rdy_dly = 2;
    eng_lat = 5;
    for (int i = 0; i < NREQ; i++) set_msg(i, MSG_A ^ N'(i * 32'h01010101));
    for (int i = 0; i < 5; i++) push_exp(order[i], MSG_A ^ N'(order[i] * 32'h01010101));
    req_valid = 4'b1111;
    res_ready = 4'b1111;
    k = 0;
    n = 0;
    while (exp_id_q.size() != 0 && n < 500) begin
      tick();
      n++;
      if (req_ready != '0 && k < 5) begin
        chk("rr_grant_order", req_ready, NREQ'(1) << order[k]);
        k++;
        if (k == 5) req_valid = '0;
      end
      if (res_valid != '0) chk("rr_res_onehot", $onehot(res_valid), 1'b1);
    end
    chk("rr_grant_count", k, 5);
    drain(50);

    // Message changed after accept
    eng_rdy_dly = 0;
    eng_lat = 4;
    set_msg(1, MSG_A);
    req_valid = 4'b0010;
    push_exp(1, MSG_A);
    wait_accept(4'b0010, "accept_req1");
    set_msg(1, MSG_B);
    req_valid = '0;
    n = 0;
    while (exp_id_q.size() != 0 && n < 100) begin
      chk("eng_md_not_B", (eng_md_in == MSG_B), 1'b0);
      tick();
      n++;
    end
    drain(50);

    // Slow consumer on requester 2 while requester 3 waits
    eng_lat = 3;
    res_ready = 4'b1011;
    set_msg(2, MSG_C);
    set_msg(3, MSG_D);
    req_valid = 4'b0100;
    push_exp(2, MSG_C);
    wait_accept(4'b0100, "accept_req2");
    req_valid = 4'b1000;
    push_exp(3, MSG_D);
    n = 0;
    while (res_valid == '0 && n < 100) begin tick(); n++; end
    for (int i = 0; i < 20; i++) begin
      chk("slow_res_valid_held", res_valid, 4'b0100);
      chk("slow_md_out_held", md_out, h(MSG_C));
      chk("slow_req3_blocked", req_ready, 4'b0000);
      tick();
    end
    res_ready = 4'b1111;
    tick();
    chk("after_deliver_idle", {req_ready, res_valid}, 8'h00);
    tick();
    chk("req3_granted_next", req_ready, 4'b1000);
    req_valid = '0;
    drain(100);

    // Reset mid-job
    eng_lat = 30;
    set_msg(1, MSG_B);
    req_valid = 4'b0010;
    wait_accept(4'b0010, "accept_pre_reset");
    req_valid = '0;
    n = 0;
    while (dbg_state != WAIT_RES && n < 100) begin tick(); n++; end
    chk("reached_wait_res", dbg_state, WAIT_RES);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) tick();
    flush();
    eng_lat = 4;
    for (int i = 0; i < NREQ; i++) set_msg(i, MSG_E ^ N'(i));
    req_valid = 4'b1111;
    rst = 1'b1;
    tick();
    chk("first_after_reset", req_ready, 4'b0001);
    req_valid = '0;
    push_exp(0, MSG_E);
    drain(100);

    // Latency counter saturation
    eng_lat = 65600;
    set_msg(2, MSG_E);
    req_valid = 4'b0100;
    push_exp(2, MSG_E);
    wait_accept(4'b0100, "accept_sat");
    req_valid = '0;
    drain(70000);
    chk("last_lat_saturated", last_lat, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
